// File: rtl/num2ascii_pkg.sv
// Shared types and constants for the binary-to-ASCII decimal streamer.
package num2ascii_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_PREP  = 3'd2,
        S_SIGN  = 3'd3,
        S_DIGIT = 3'd4,
        S_CR    = 3'd5,
        S_LF    = 3'd6
    } state_t;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // ceil(width*log10(2)): decimal digits needed for the largest width-bit magnitude
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 32'd30103 + 32'd99999) / 32'd100000;
    endfunction

endpackage

// File: rtl/num2ascii_stream_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, WIDTH cycles per conversion.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  fin
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned REG_W = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [REG_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift
    function automatic logic [REG_W-1:0] add3(input logic [REG_W-1:0] r);
        logic [REG_W-1:0] o;
        o = r;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (o[WIDTH+4*d +: 4] >= 4'd5) begin
                o[WIDTH+4*d +: 4] = o[WIDTH+4*d +: 4] + 4'd3;
            end
        end
        return o;
    endfunction

    // The load cycle performs the first shift (all BCD nibbles are still zero)
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        fin_d  = 1'b0;
        if (en) begin
            sr_d   = {{(BCD_W-1){1'b0}}, bin, 1'b0};
            cnt_d  = CNT_W'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = add3(sr_q) << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                fin_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            fin_q  <= fin_d;
        end
    end

    assign bcd  = sr_q[REG_W-1 -: BCD_W];
    assign busy = busy_q;
    assign fin  = fin_q;

endmodule

// File: rtl/num2ascii_stream.sv
// Converts a binary value to decimal ASCII and streams it MSD-first over valid/ready.
module num2ascii_stream
    import num2ascii_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DIGITS         = 10,
    parameter bit          SIGNED         = 1'b0,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    parameter bit          TERM_EN        = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             busy_o,
    output logic [7:0]       char_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             done_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("num2ascii_stream: WIDTH must be within 2..64");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("num2ascii_stream: DIGITS too small for WIDTH");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             neg_q, neg_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             conv_en_c;
    logic             xfer_c;
    logic             finish_c;
    logic [WIDTH-1:0] mag_c;
    logic [IDX_W-1:0] first_idx_c;
    logic [BCD_W-1:0] bcd;
    logic             conv_busy;
    logic             conv_fin;

    function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] b,
                                              input logic [IDX_W-1:0] i);
        return CH_ZERO + {4'h0, b[4*i +: 4]};
    endfunction

    // Two's complement magnitude; the most negative value maps onto itself as unsigned
    always_comb begin
        mag_c = value_i;
        if (SIGNED && value_i[WIDTH-1]) begin
            mag_c = ~value_i + WIDTH'(1);
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .CLK  (CLK),
        .RST  (RST),
        .en   (conv_en_c),
        .bin  (mag_c),
        .bcd  (bcd),
        .busy (conv_busy),
        .fin  (conv_fin)
    );

    // Highest nonzero digit when suppressing; an all-zero value still yields digit 0
    always_comb begin
        first_idx_c = IDX_W'(DIGITS - 1);
        if (SUPPRESS_ZEROS) begin
            first_idx_c = '0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (bcd[4*i +: 4] != 4'h0) begin
                    first_idx_c = IDX_W'(i);
                end
            end
        end
    end

    assign xfer_c = valid_q && ready_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        neg_d     = neg_q;
        char_d    = char_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        conv_en_c = 1'b0;
        finish_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    conv_en_c = 1'b1;
                    neg_d     = SIGNED && value_i[WIDTH-1];
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                if (conv_fin && !conv_busy) begin
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                idx_d   = first_idx_c;
                valid_d = 1'b1;
                if (neg_q) begin
                    state_d = S_SIGN;
                    char_d  = CH_MINUS;
                end else begin
                    state_d = S_DIGIT;
                    char_d  = digit_char(bcd, first_idx_c);
                end
            end
            S_SIGN: begin
                if (xfer_c) begin
                    state_d = S_DIGIT;
                    char_d  = digit_char(bcd, idx_q);
                end
            end
            S_DIGIT: begin
                if (xfer_c) begin
                    if (idx_q == '0) begin
                        if (TERM_EN) begin
                            state_d = S_CR;
                            char_d  = CH_CR;
                        end else begin
                            finish_c = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q - IDX_W'(1);
                        char_d = digit_char(bcd, idx_q - IDX_W'(1));
                    end
                end
            end
            S_CR: begin
                if (xfer_c) begin
                    state_d = S_LF;
                    char_d  = CH_LF;
                end
            end
            S_LF: begin
                if (xfer_c) begin
                    finish_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish_c) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            char_d  = 8'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            neg_q   <= neg_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign char_o  = char_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_num2ascii_stream.sv
// Bench for num2ascii_stream: three parameterisations checked against a decimal-string model.
module tb_num2ascii_stream;

    localparam int CW [3] = '{32, 8, 32};
    localparam int CD [3] = '{10, 3, 10};
    localparam bit CS [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit CZ [3] = '{1'b1, 1'b1, 1'b0};
    localparam bit CT [3] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [63:0] val;
    logic        rdy;
    logic [7:0]  ch  [3];
    logic        vld [3];
    logic        bsy [3];
    logic        dn  [3];

    int          sel;
    logic [7:0]  ch_s;
    logic        v_s, b_s, d_s;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    logic [7:0]  expq [$];
    logic [7:0]  gotq [$];
    logic [7:0]  mon_e;
    bit          pv, pr, last_prev;
    logic [7:0]  pch;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    num2ascii_stream #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0), .SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b1)) u_dflt (
        .CLK(clk), .RST(rst), .start_i(start_v[0]), .value_i(val[31:0]), .busy_o(bsy[0]),
        .char_o(ch[0]), .valid_o(vld[0]), .ready_i(rdy), .done_o(dn[0]));

    num2ascii_stream #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1), .SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b0)) u_s8 (
        .CLK(clk), .RST(rst), .start_i(start_v[1]), .value_i(val[7:0]), .busy_o(bsy[1]),
        .char_o(ch[1]), .valid_o(vld[1]), .ready_i(rdy), .done_o(dn[1]));

    num2ascii_stream #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0), .SUPPRESS_ZEROS(1'b0), .TERM_EN(1'b1)) u_nz (
        .CLK(clk), .RST(rst), .start_i(start_v[2]), .value_i(val[31:0]), .busy_o(bsy[2]),
        .char_o(ch[2]), .valid_o(vld[2]), .ready_i(rdy), .done_o(dn[2]));

    always_comb begin
        ch_s = ch[sel];
        v_s  = vld[sel];
        b_s  = bsy[sel];
        d_s  = dn[sel];
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk_str(input string nm, input logic [7:0] q[$], input string exp);
        string g = "";
        string e = "";
        foreach (q[i]) g = {g, $sformatf("%02h ", q[i])};
        for (int i = 0; i < exp.len(); i++) e = {e, $sformatf("%02h ", exp[i])};
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s: got bytes [%s] want [%s]", nm, g, e);
        end
    endfunction

    // Expected byte stream from plain decimal arithmetic on the value
    function automatic void model(input int s, input logic [63:0] v, output logic [7:0] q[$]);
        logic [63:0] m;
        logic        neg;
        q   = {};
        m   = v & ((64'd1 << CW[s]) - 64'd1);
        neg = CS[s] && m[CW[s]-1];
        if (neg) m = (64'd1 << CW[s]) - m;
        do begin
            q.push_front(8'h30 + 8'(m % 64'd10));
            m = m / 64'd10;
        end while (m != 0);
        if (!CZ[s]) while (q.size() < CD[s]) q.push_front(8'h30);
        if (neg) q.push_front(8'h2D);
        if (CT[s]) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endfunction

    // Per-cycle compare: byte order, stall stability, done pulse timing
    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_pulse", 64'(d_s), 64'(last_prev));
            last_prev = 1'b0;
            if (pv && !pr) begin
                chk("hold_valid", 64'(v_s), 64'd1);
                chk("hold_char", 64'(ch_s), 64'(pch));
            end
            if (v_s && rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_byte", 64'(ch_s), 64'hFFFF);
                end else begin
                    mon_e = expq.pop_front();
                    chk("byte", 64'(ch_s), 64'(mon_e));
                    gotq.push_back(ch_s);
                    if (expq.size() == 0) last_prev = 1'b1;
                end
            end
            pv  = v_s;
            pr  = rdy;
            pch = ch_s;
        end else begin
            pv        = 1'b0;
            last_prev = 1'b0;
        end
    end

    task automatic run(input int s, input logic [63:0] v, input int stall, input bit dup,
                       output logic [7:0] got[$]);
        logic [7:0] e[$];
        int  t0, t1;
        bit  seen_v, seen_d;
        model(s, v, e);
        @(posedge clk); #1;
        sel        = s;
        expq       = e;
        gotq       = {};
        val        = v;
        rdy        = 1'b1;
        start_v[s] = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        val        = {$urandom, $urandom};
        seen_v = 1'b0;
        seen_d = 1'b0;
        t1     = 0;
        for (int k = 0; k < 3000 && !seen_d; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_start", 64'(b_s), 64'd1);
            if (v_s && !seen_v) begin
                seen_v = 1'b1;
                t1     = cyc;
            end
            if (d_s) begin
                seen_d = 1'b1;
                chk("busy_at_done", 64'(b_s), 64'd0);
            end
            if (!seen_d) begin
                @(posedge clk); #1;
                rdy        = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
                start_v[s] = dup && (k == 2 || k == 20);
            end
        end
        chk("done_seen", 64'(seen_d), 64'd1);
        chk("first_valid_latency", 64'(t1 - t0), 64'(CW[s] + 2));
        chk("bytes_left", 64'(expq.size()), 64'd0);
        @(posedge clk); #1;
        start_v = '0;
        rdy     = 1'b1;
        repeat (3) @(posedge clk);
        got = gotq;
    endtask

    task automatic abort_run();
        logic [7:0] e[$];
        bit found;
        model(0, 64'd907, e);
        @(posedge clk); #1;
        sel        = 0;
        expq       = e;
        val        = 64'd907;
        rdy        = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (v_s && ch_s == 8'h30) begin
                rdy   = 1'b0;
                found = 1'b1;
            end
        end
        chk("abort_found_zero", 64'(found), 64'd1);
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("abort_pending_valid", 64'(v_s), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(v_s), 64'd0);
        chk("abort_busy", 64'(b_s), 64'd0);
        chk("abort_done", 64'(d_s), 64'd0);
        chk("abort_char", 64'(ch_s), 64'd0);
        @(negedge clk);
        chk("abort_no_done_later", 64'(d_s), 64'd0);
        chk("abort_still_idle", 64'(v_s), 64'd0);
        expq   = {};
        rdy    = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g[$];
        rst     = 1'b1;
        start_v = '0;
        val     = '0;
        rdy     = 1'b1;
        sel     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 64'(vld[i]), 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("rst_done%0d", i), 64'(dn[i]), 64'd0);
            chk($sformatf("rst_char%0d", i), 64'(ch[i]), 64'd0);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        run(0, 64'd12345, 0, 1'b0, g);        chk_str("dflt_12345", g, "12345\015\012");
        run(0, 64'd0, 0, 1'b0, g);            chk_str("dflt_zero", g, "0\015\012");
        run(0, 64'hFFFF_FFFF, 0, 1'b0, g);    chk_str("dflt_max", g, "4294967295\015\012");
        run(1, 64'h80, 0, 1'b0, g);           chk_str("s8_min", g, "-128");
        run(1, 64'hFF, 0, 1'b0, g);           chk_str("s8_m1", g, "-1");
        run(1, 64'h7F, 0, 1'b0, g);           chk_str("s8_max", g, "127");
        run(2, 64'd42, 0, 1'b0, g);           chk_str("nz_42", g, "0000000042\015\012");
        run(0, 64'd907, 0, 1'b0, g);          chk_str("dflt_907", g, "907\015\012");
        run(0, 64'd907, 50, 1'b1, g);         chk_str("dflt_907_stall", g, "907\015\012");

        abort_run();
        run(0, 64'd907, 30, 1'b0, g);         chk_str("dflt_907_after_abort", g, "907\015\012");

        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 3; s++) begin
                run(s, {$urandom, $urandom}, int'($urandom_range(60)), 1'b0, g);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
